// File: rtl/fft_mem_sequencer.sv
// Frame controller for the FFT working memory: bit-reversed load, per-stage
// butterfly address generation, natural-order unload, and the memory port mux.
module fft_mem_sequencer #(
  parameter int LOG2N = 8,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             bf_req,
  input  logic             bf_ack,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [LOG2N-2:0] bf_tw_idx,
  input  logic             bf_mem_wr_en,
  input  logic [LOG2N-1:0] bf_mem_wr_addr,
  input  logic [DW-1:0]    bf_mem_wr_data,
  input  logic             bf_mem_rd_en,
  input  logic [LOG2N-1:0] bf_mem_rd_addr,
  output logic             mem_wr_en,
  output logic [LOG2N-1:0] mem_wr_addr,
  output logic [DW-1:0]    mem_wr_data,
  output logic             mem_rd_en,
  output logic [LOG2N-1:0] mem_rd_addr,
  input  logic [DW-1:0]    mem_rd_data
);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD    | accepting N input samples, written at bit-reversed addresses
  // COMPUTE | butterfly unit owns the memory port, LOG2N stages of N/2 pairs
  // UNLOAD  | reading memory in natural order to the output stream
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam logic [LOG2N-1:0] CNT_LAST   = {LOG2N{1'b1}};
  localparam logic [LOG2N-2:0] BFLY_LAST  = {(LOG2N-1){1'b1}};
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N-1);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] cnt, cnt_nxt;
  logic [SW-1:0]    stage, stage_nxt;
  logic [LOG2N-2:0] bfly, bfly_nxt;
  logic             req_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             out_valid_nxt;
  logic [DW-1:0]    out_data_nxt;

  logic [SW:0]      stage_p1;
  logic [SW-1:0]    tw_sh;
  logic [LOG2N-2:0] j_mask, j;
  logic [LOG2N-1:0] half, addr_a;
  logic [LOG2N-2:0] tw;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Pair address: insert a 0 at bit position 'stage' of the butterfly index.
  assign stage_p1 = {1'b0, stage} + 1'b1;
  assign tw_sh    = STAGE_LAST - stage;
  assign j_mask   = ((LOG2N-1)'(1) << stage) - 1'b1;
  assign j        = bfly & j_mask;
  assign half     = LOG2N'(1) << stage;
  assign addr_a   = (({1'b0, bfly} >> stage) << stage_p1) | {1'b0, j};
  assign tw       = j << tw_sh;

  assign bf_addr_a = bf_req ? addr_a : '0;
  assign bf_addr_b = bf_req ? (addr_a | half) : '0;
  assign bf_tw_idx = bf_req ? tw : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      stage     <= '0;
      bfly      <= '0;
      bf_req    <= 1'b0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stage     <= stage_nxt;
      bfly      <= bfly_nxt;
      bf_req    <= req_nxt;
      rd_pend   <= rd_pend_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stage_nxt     = stage;
    bfly_nxt      = bfly;
    req_nxt       = bf_req;
    rd_pend_nxt   = 1'b0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    in_ready      = 1'b0;
    done          = 1'b0;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = bitrev(cnt);
          mem_wr_data = in_data;
          cnt_nxt     = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        mem_wr_en   = bf_mem_wr_en;
        mem_wr_addr = bf_mem_wr_addr;
        mem_wr_data = bf_mem_wr_data;
        mem_rd_en   = bf_mem_rd_en;
        mem_rd_addr = bf_mem_rd_addr;
        if (!bf_req) begin
          req_nxt = 1'b1;
        end else if (bf_ack) begin
          req_nxt = 1'b0;
          if (bfly == BFLY_LAST) begin
            bfly_nxt = '0;
            if (stage == STAGE_LAST) begin
              stage_nxt = '0;
              state_nxt = UNLOAD;
            end else begin
              stage_nxt = stage + 1'b1;
            end
          end else begin
            bfly_nxt = bfly + 1'b1;
          end
        end
      end
      UNLOAD: begin
        if (rd_pend) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = mem_rd_data;
        end
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          cnt_nxt       = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        // Prefetch the next word in the accept cycle to sustain 1 word / 2 cycles.
        if (!rd_pend && (!out_valid || (out_ready && cnt != CNT_LAST))) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = out_valid ? cnt + 1'b1 : cnt;
          rd_pend_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Scoreboard bench for fft_mem_sequencer with a behavioural memory and a
// butterfly model that read-modify-writes the top element of each pair.
module tb_fft_mem_sequencer;
  localparam int LOG2N = 8;
  localparam int DW    = 32;
  localparam int N     = 1 << LOG2N;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, in_ready, out_valid, bf_req;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic             bf_ack = 1'b0;
  logic [LOG2N-1:0] bf_addr_a, bf_addr_b;
  logic [LOG2N-2:0] bf_tw_idx;
  logic             bf_mem_wr_en = 1'b0;
  logic [LOG2N-1:0] bf_mem_wr_addr = '0;
  logic [DW-1:0]    bf_mem_wr_data = '0;
  logic             bf_mem_rd_en = 1'b0;
  logic [LOG2N-1:0] bf_mem_rd_addr = '0;
  logic             mem_wr_en, mem_rd_en;
  logic [LOG2N-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0]    mem_wr_data;
  logic [DW-1:0]    mem_rd_data;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] exp_mem [N];
  logic [DW-1:0] sb_q [$];
  int total = 0;
  int bad = 0;

  fft_mem_sequencer #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bf_req(bf_req), .bf_ack(bf_ack), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw_idx(bf_tw_idx), .bf_mem_wr_en(bf_mem_wr_en), .bf_mem_wr_addr(bf_mem_wr_addr),
    .bf_mem_wr_data(bf_mem_wr_data), .bf_mem_rd_en(bf_mem_rd_en),
    .bf_mem_rd_addr(bf_mem_rd_addr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    next_cyc();
    start = 1'b1;
    #1;
    chk("start_idle_busy", busy, 0);
    next_cyc();
    start = 1'b0;
    #1;
    chk("load_busy", busy, 1);
    chk("load_in_ready", in_ready, 1);
  endtask

  task automatic load_frame(input logic [31:0] base, input bit gaps);
    int i = 0;
    for (int cyc = 0; cyc < 2000 && i < N; cyc++) begin
      next_cyc();
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = base + 32'(i);
      start    = (i == 100);
      #1;
      if (in_valid && in_ready) begin
        chk("load_wr_en", mem_wr_en, 1);
        chk("load_wr_addr", mem_wr_addr, bitrev8(8'(i)));
        chk("load_wr_data", mem_wr_data, in_data);
        chk("load_no_rd", mem_rd_en, 0);
        exp_mem[bitrev8(8'(i))] = in_data;
        i++;
      end else if (!in_valid) begin
        chk("load_idle_wr", mem_wr_en, 0);
      end
    end
    chk("load_count", i, N);
    next_cyc();
    in_valid = 1'b0;
    start    = 1'b0;
    #1;
    chk("load_end_in_ready", in_ready, 0);
    chk("compute_busy", busy, 1);
    chk("compute_entry_req", bf_req, 0);
  endtask

  task automatic compute(input int stop_stage);
    int s_m = 0, k_m = 0, reqs = 0, phase = 0, jm;
    bit fin = 0;
    logic [7:0] a_m, b_m;
    logic [6:0] tw_m;
    logic [31:0] rd_val = '0, pat;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      next_cyc();
      bf_ack = 1'b0; bf_mem_wr_en = 1'b0; bf_mem_rd_en = 1'b0; start = 1'b0;
      jm   = k_m % (1 << s_m);
      a_m  = 8'((k_m / (1 << s_m)) * (2 << s_m) + jm);
      b_m  = a_m + 8'(1 << s_m);
      tw_m = 7'(jm * (1 << (7 - s_m)));
      case (phase)
        0: begin
          chk("req_assert", bf_req, 1);
          if (!bf_req) begin
            fin = 1;
          end else if (s_m == stop_stage) begin
            bf_mem_rd_en = 1'b1; bf_mem_rd_addr = a_m;
            bf_mem_wr_en = 1'b1; bf_mem_wr_addr = a_m;
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_req", bf_req, 0);
            chk("rst_rd_en", mem_rd_en, 0);
            chk("rst_wr_en", mem_wr_en, 0);
            chk("rst_addr_b", bf_addr_b, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            bf_mem_rd_en = 1'b0; bf_mem_wr_en = 1'b0;
            next_cyc();
            rst_n = 1'b1;
            fin = 1;
          end else begin
            chk("addr_a", bf_addr_a, a_m);
            chk("addr_b", bf_addr_b, b_m);
            chk("tw_idx", bf_tw_idx, tw_m);
            reqs++;
            if (reqs == 11) start = 1'b1;
            bf_mem_rd_en = 1'b1; bf_mem_rd_addr = a_m;
            #1;
            chk("cmp_rd_en", mem_rd_en, 1);
            chk("cmp_rd_addr", mem_rd_addr, a_m);
            chk("cmp_no_wr", mem_wr_en, 0);
            phase = 1;
          end
        end
        1: begin
          rd_val = mem_rd_data;
          chk("cmp_rd_data", rd_val, exp_mem[a_m]);
          chk("req_hold", bf_req, 1);
          chk("addr_hold", bf_addr_a, a_m);
          phase = 2;
        end
        2: begin
          pat = {16'hA5A5, 8'(s_m), 8'(k_m)};
          bf_ack = 1'b1;
          bf_mem_wr_en = 1'b1; bf_mem_wr_addr = a_m; bf_mem_wr_data = rd_val ^ pat;
          #1;
          chk("cmp_wr_en", mem_wr_en, 1);
          chk("cmp_wr_addr", mem_wr_addr, a_m);
          chk("cmp_wr_data", mem_wr_data, rd_val ^ pat);
          exp_mem[a_m] = exp_mem[a_m] ^ pat;
          if (k_m == N/2 - 1) begin k_m = 0; s_m++; end
          else k_m++;
          phase = 3;
          if (s_m == LOG2N) fin = 1;
        end
        default: begin
          chk("req_drop", bf_req, 0);
          chk("compute_busy_hold", busy, 1);
          phase = 0;
        end
      endcase
    end
    if (stop_stage >= LOG2N) chk("req_count", reqs, 1024);
  endtask

  task automatic unload();
    int rd_exp = 0, done_cnt = 0;
    bit holding = 0;
    logic [31:0] hold = '0, e;
    for (int a = 0; a < N; a++) sb_q.push_back(exp_mem[a]);
    for (int cyc = 0; cyc < 4000 && sb_q.size() > 0; cyc++) begin
      next_cyc();
      bf_ack = 1'b1; bf_mem_wr_en = 1'b1; bf_mem_rd_en = 1'b1;
      bf_mem_wr_addr = 8'hFF; bf_mem_rd_addr = 8'hFF;
      if (cyc == 0) chk("unload_req_low", bf_req, 0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("unload_no_wr", mem_wr_en, 0);
      if (holding) begin
        chk("valid_hold", out_valid, 1);
        chk("out_hold", out_data, hold);
      end
      holding = out_valid && !out_ready;
      hold    = out_data;
      if (mem_rd_en) begin
        chk("unload_rd_addr", mem_rd_addr, rd_exp);
        rd_exp++;
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        e = sb_q.pop_front();
        chk("out_data", out_data, e);
        chk("done_pulse", done, sb_q.size() == 0);
      end
    end
    chk("unload_left", sb_q.size(), 0);
    chk("rd_issued", rd_exp, N);
    next_cyc();
    bf_ack = 1'b0; bf_mem_wr_en = 1'b0; bf_mem_rd_en = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state_busy", busy, 0);
    chk("rst_state_done", done, 0);
    chk("rst_state_in_ready", in_ready, 0);
    chk("rst_state_out_valid", out_valid, 0);
    chk("rst_state_bf_req", bf_req, 0);
    chk("rst_state_wr_en", mem_wr_en, 0);
    chk("rst_state_rd_en", mem_rd_en, 0);
    chk("rst_state_out_data", out_data, 0);
    chk("rst_state_addr_a", bf_addr_a, 0);
    chk("rst_state_addr_b", bf_addr_b, 0);
    chk("rst_state_tw", bf_tw_idx, 0);
    chk("rst_state_wr_addr", mem_wr_addr, 0);
    chk("rst_state_rd_addr", mem_rd_addr, 0);
    rst_n = 1'b1;

    pulse_start();
    load_frame(32'h0000_0000, 1'b0);
    compute(LOG2N);
    unload();

    pulse_start();
    load_frame(32'h1000_0000, 1'b1);
    compute(3);
    #1;
    chk("post_rst_busy", busy, 0);

    pulse_start();
    load_frame(32'h2000_0000, 1'b1);
    compute(LOG2N);
    unload();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
